// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor.
package compositor_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        HOLD     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    localparam logic [23:0] WHITE = 24'hFFFFFF;

endpackage

// File: rtl/flash_timer.sv
// Per-layer hit-flash down-counter; the layer renders white while the count is odd.
module flash_timer #(
    parameter int FLASH_FRAMES = 6,
    parameter int CW           = $clog2(FLASH_FRAMES + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          hit,
    input  logic          frame_start,
    output logic [CW-1:0] cnt,
    output logic          flash_on
);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // A hit (re)loads the full duration and beats a coincident frame tick
    always_comb begin
        cnt_d = cnt_q;
        if (hit) begin
            cnt_d = CW'(FLASH_FRAMES);
        end else if (frame_start && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign flash_on = cnt_q[0];

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer compositor: priority select with hit-flash, then brightness scaling
// driven by a frame-synchronous fade sequencer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | full brightness, waiting for scene_change
//   FADE_OUT | level steps down once per frame until black
//   HOLD     | black; hold counter steps down once per frame
//   FADE_IN  | level steps up once per frame until full brightness
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int N_LAYERS     = 4,
    parameter int LEVEL_BITS   = 4,
    parameter int FADE_STEP    = 1,
    parameter int FLASH_FRAMES = 6,
    parameter int HOLD_FRAMES  = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_start,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic [N_LAYERS-1:0]   layer_on,
    input  logic [24*N_LAYERS-1:0] layer_rgb,
    input  logic [23:0]           bg_rgb,
    input  logic [N_LAYERS-1:0]   layer_hit,
    input  logic                  scene_change,
    output logic [7:0]            VGA_R,
    output logic [7:0]            VGA_G,
    output logic [7:0]            VGA_B,
    output logic [9:0]            pix_x,
    output logic [9:0]            pix_y,
    output logic                  stage_swap,
    output logic                  fade_busy
);

    localparam int LW = LEVEL_BITS + 1;
    localparam int PW = 8 + LEVEL_BITS + 1;
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [LW-1:0] LMAX = LW'(1) << LEVEL_BITS;
    localparam logic [LW:0]   STEP = (LW+1)'(FADE_STEP);

    // Product is one bit wider than needed so level=LMAX passes the channel through
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [LW-1:0] lvl);
        logic [PW-1:0] prod;
        prod = PW'(c) * PW'(lvl);
        return 8'(prod >> LEVEL_BITS);
    endfunction

    logic [N_LAYERS-1:0]          flash_on;
    logic [N_LAYERS-1:0][FW-1:0]  flash_cnt;
    logic                         unused_flash_cnt;

    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_flash
        flash_timer #(
            .FLASH_FRAMES (FLASH_FRAMES),
            .CW           (FW)
        ) u_flash (
            .Clk         (Clk),
            .Reset       (Reset),
            .hit         (layer_hit[gi]),
            .frame_start (frame_start),
            .cnt         (flash_cnt[gi]),
            .flash_on    (flash_on[gi])
        );
    end

    // Full counts are kept on the timer ports for debug visibility only
    assign unused_flash_cnt = ^flash_cnt;

    fade_state_t   state_d, state_q;
    logic [LW-1:0] level_d, level_q;
    logic [HW-1:0] hold_d, hold_q;
    logic          stage_swap_d, stage_swap_q;
    logic [LW:0]   level_up, level_dn;

    rgb_t          sel_d, sel_q;
    rgb_t          out_d, out_q;
    logic [9:0]    x1_d, x1_q, y1_d, y1_q;
    logic [9:0]    x2_d, x2_q, y2_d, y2_q;

    // Fade sequencer: every level change is gated by frame_start
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        hold_d       = hold_q;
        stage_swap_d = 1'b0;
        level_up     = {1'b0, level_q} + STEP;
        level_dn     = ({1'b0, level_q} > STEP) ? ({1'b0, level_q} - STEP) : '0;
        case (state_q)
            IDLE: begin
                level_d = LMAX;
                if (scene_change) begin
                    state_d = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (frame_start) begin
                    level_d = level_dn[LW-1:0];
                    if (level_dn == '0) begin
                        state_d      = HOLD;
                        hold_d       = HW'(HOLD_FRAMES);
                        stage_swap_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (frame_start) begin
                    if (hold_q <= HW'(1)) begin
                        hold_d  = '0;
                        state_d = FADE_IN;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
            end
            FADE_IN: begin
                if (scene_change) begin
                    state_d = FADE_OUT;
                end else if (frame_start) begin
                    if (level_up >= {1'b0, LMAX}) begin
                        level_d = LMAX;
                        state_d = IDLE;
                    end else begin
                        level_d = level_up[LW-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fade sequencer registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            level_q      <= LMAX;
            hold_q       <= '0;
            stage_swap_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            stage_swap_q <= stage_swap_d;
        end
    end

    // Stage 1 picks the lowest-index opaque layer; stage 2 scales by the live level
    always_comb begin
        sel_d = rgb_t'(bg_rgb);
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_on[i]) begin
                sel_d = flash_on[i] ? rgb_t'(WHITE) : rgb_t'(layer_rgb[24*i +: 24]);
            end
        end
        x1_d    = DrawX;
        y1_d    = DrawY;
        out_d.r = scale(sel_q.r, level_q);
        out_d.g = scale(sel_q.g, level_q);
        out_d.b = scale(sel_q.b, level_q);
        x2_d    = x1_q;
        y2_d    = y1_q;
    end

    // Pipeline registers; never stalled
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_q <= '0;
            x1_q  <= '0;
            y1_q  <= '0;
            out_q <= '0;
            x2_q  <= '0;
            y2_q  <= '0;
        end else begin
            sel_q <= sel_d;
            x1_q  <= x1_d;
            y1_q  <= y1_d;
            out_q <= out_d;
            x2_q  <= x2_d;
            y2_q  <= y2_d;
        end
    end

    assign VGA_R      = out_q.r;
    assign VGA_G      = out_q.g;
    assign VGA_B      = out_q.b;
    assign pix_x      = x2_q;
    assign pix_y      = y2_q;
    assign stage_swap = stage_swap_q;
    assign fade_busy  = (state_q != IDLE);

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
Parametrised, pipelined successor to the per-pixel colour mapper. It composites N_LAYERS prioritised sprite/text layers over a background colour. Each layer can show a frame-counted hit-flash, and a frame-synchronous fade-out/fade-in sequencer runs on every game-stage change. The block sits between the sprite/word generators and the VGA output, and the VGA sync path is delayed to match its fixed 2-cycle latency.

Parameters:
N_LAYERS, 4, number of composited layers; index 0 has the highest priority.
LEVEL_BITS, 4, brightness resolution; full brightness LMAX = 2**LEVEL_BITS.
FADE_STEP, 1, brightness change per frame while fading.
FLASH_FRAMES, 6, frames a hit-flash lasts; must be at least 1.
HOLD_FRAMES, 2, frames held at black between fade-out and fade-in.

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse per frame (start of vertical blank)
DrawX, DrawY  in  10 each  current pixel coordinates
layer_on  in  N_LAYERS  per-layer pixel-opaque flags
layer_rgb  in  24*N_LAYERS  packed colours; layer i occupies bits [24i+23:24i], R in the MS byte
bg_rgb  in  24  background colour
layer_hit  in  N_LAYERS  one-cycle hit pulses
scene_change  in  1  one-cycle request to start a fade sequence
VGA_R, VGA_G, VGA_B  out  8 each  composited, scaled colour
pix_x, pix_y  out  10 each  DrawX/DrawY delayed by 2 cycles
stage_swap  out  1  one-cycle pulse when the fade reaches black
fade_busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset values: VGA_R/G/B=0, pix_x/pix_y=0, stage_swap=0, fade_busy=0, FSM=IDLE, level=LMAX, all flash counters 0, hold counter 0.
- Latency: inputs sampled at edge t appear on the outputs after edge t+2. The pipeline is never stalled and accepts one pixel per cycle.
- Stage 1 (select):
  - The winner is the lowest index i with layer_on[i]=1; bg_rgb is used if no layer is on.
  - If the winner is layer i and flash_cnt[i][0]=1, the selected colour is forced to 24'hFFFFFF.
  - The background never flashes.
- Stage 2 (scale):
  - Each channel is computed as c_out = (c * level) >> LEVEL_BITS, with the product 8+LEVEL_BITS+1 bits wide.
  - level=LMAX returns c unchanged; level=0 returns 0.
  - level is sampled in stage 2, so a level change takes effect on the pixel then in stage 2.
- Flash counters, one per layer:
  - layer_hit[i] loads FLASH_FRAMES.
  - Otherwise frame_start decrements the counter if it is non-zero.
  - A hit and frame_start in the same cycle: the load wins.
  - A hit while the counter is non-zero reloads it.
  - With FLASH_FRAMES=6 the layer renders white on the frames where the count is 5, 3 and 1.
- Fade FSM states: IDLE, FADE_OUT, HOLD, FADE_IN.
  - IDLE: on scene_change go to FADE_OUT. level stays LMAX.
  - FADE_OUT: on each frame_start, level = max(level-FADE_STEP, 0). When the updated level is 0, go to HOLD, load the hold counter with HOLD_FRAMES and pulse stage_swap for exactly one cycle (the same edge).
  - HOLD: on each frame_start decrement the hold counter. When it reaches 0, go to FADE_IN.
  - FADE_IN: on each frame_start, level = min(level+FADE_STEP, LMAX). When it reaches LMAX, go to IDLE.
  - scene_change is ignored in FADE_OUT and HOLD.
  - scene_change in FADE_IN goes to FADE_OUT with level continuing from its current value. No second reset-to-LMAX occurs.
  - The FSM advances only on frame_start, so no level change happens mid-frame.
- Reset asserted mid-fade or mid-flash forces all reset values on the next edge. Pipeline contents are discarded (outputs 0).
- Simultaneous scene_change and frame_start in IDLE: the FSM enters FADE_OUT, and the first decrement happens on the next frame_start.

Decomposition:
- Package compositor_pkg holds:
  - typedef rgb_t: a packed struct of r, g, b, 8 bits each.
  - enum fade_state_t {IDLE, FADE_OUT, HOLD, FADE_IN}.
  - localparam WHITE=24'hFFFFFF.
- One sub-module, flash_timer: a per-layer counter with inputs hit and frame_start and outputs cnt and flash_on, instantiated N_LAYERS times by generate.
- The fade FSM and the two pipeline stages stay in layer_compositor.

Test Plan:
- Priority/latency: layer_on=4'b0110, layer1=0x112233, layer2=0xAABBCC -> 0x112233 on VGA two cycles later; pix_x/pix_y equal DrawX/DrawY from two cycles earlier; layer_on=0 -> bg_rgb.
- Flash: pulse layer_hit[1] with layer 1 winning, then 6 frame_starts -> output white on frames 1, 3 and 5 after the hit (counts 5, 3, 1) and 0x112233 otherwise; a second hit at count 3 reloads to 6.
- Hit and frame_start in the same cycle -> counter equals FLASH_FRAMES, not FLASH_FRAMES-1.
- Full fade (LEVEL_BITS=4, FADE_STEP=1, HOLD_FRAMES=2): scene_change on a 0xFF colour -> output 0xEF after 1 frame_start and 0x00 after 16; stage_swap pulses once at the 16th frame_start; black held for 2 frames; 16 frames later the output is back at 0xFF and fade_busy=0.
- scene_change during FADE_IN at level 7 -> FADE_OUT resumes from 7 and reaches 0 after 7 frame_starts; scene_change during HOLD -> no effect.
- Reset asserted while in FADE_OUT at level 9 with a flash counter at 4 -> next cycle: IDLE, level=LMAX, counters 0, VGA outputs 0, fade_busy=0.
